valu_fadd_lane_sequencer: RTL and testbench

- Multi-cycle controller that shares one `float_adder_32` instance across the lanes of a vector FP32 add request in the Vector ALU.
- Accepts a LANES-wide operand bundle with an exec mask and issues each active lane to the shared adder in turn.
- Collects each lane's result and NaN/overflow flags, then returns one packed response over a valid/ready handshake.
- The adder itself is external; this block drives its inputs and samples its outputs.

---
 rtl/valu_fadd_lane_sequencer_if.sv | 27 ++
 rtl/valu_fadd_lane_sequencer.sv | 140 ++++++++++++++
 tb/tb_valu_fadd_lane_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/valu_fadd_lane_sequencer_if.sv
// Request/response handshake bundle for the vector FP32 add lane sequencer.
// The master side issues requests and consumes responses.
interface valu_fadd_lane_sequencer_if #(
    parameter int LANES = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic [LANES*32-1:0]   req_a;
    logic [LANES*32-1:0]   req_b;
    logic [LANES-1:0]      req_exec;
    logic                  req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [LANES*32-1:0]   rsp_data;
    logic [LANES-1:0]      rsp_nan_mask;
    logic [LANES-1:0]      rsp_ovf_mask;

    modport master (
        output req_valid, req_a, req_b, req_exec, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_nan_mask, rsp_ovf_mask
    );

    modport slave (
        input  req_valid, req_a, req_b, req_exec, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_nan_mask, rsp_ovf_mask
    );
endinterface

// File: rtl/valu_fadd_lane_sequencer.sv
// Time-multiplexes one shared FP32 adder across the active lanes of a request.
// Define VALU_FADD_SUB_EN to honour req_op (subtract by flipping B's sign).
module valu_fadd_lane_sequencer #(
    parameter int LANES   = 4,
    parameter int ADD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    valu_fadd_lane_sequencer_if.slave bus,
    output logic [31:0] fadd_a,
    output logic [31:0] fadd_b,
    input  logic [31:0] fadd_out,
    input  logic        fadd_nan,
    input  logic        fadd_ovf,
    output logic        busy
);
    localparam int LW = $clog2(LANES);
    localparam int CW = $clog2(ADD_LAT + 1);
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t               state;
    logic [LW-1:0]        lane;
    logic [CW-1:0]        cnt;
    logic [LANES*32-1:0]  a_q;
    logic [LANES*32-1:0]  b_q;
    logic [LANES-1:0]     exec_q;
    logic                 req_ready_q;
    logic                 rsp_valid_q;
    logic [LANES*32-1:0]  data_q;
    logic [LANES-1:0]     nan_q;
    logic [LANES-1:0]     ovf_q;
    logic [31:0]          a_lane;
    logic [31:0]          b_lane;

`ifdef VALU_FADD_SUB_EN
    logic                 op_q;
`else
    logic                 unused_req_op;
    assign unused_req_op = bus.req_op;
`endif

    assign a_lane = a_q[{lane, 5'd0} +: 32];
    assign b_lane = b_q[{lane, 5'd0} +: 32];

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = data_q;
    assign bus.rsp_nan_mask = nan_q;
    assign bus.rsp_ovf_mask = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            lane        <= '0;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            exec_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            data_q      <= '0;
            nan_q       <= '0;
            ovf_q       <= '0;
            fadd_a      <= '0;
            fadd_b      <= '0;
            busy        <= 1'b0;
`ifdef VALU_FADD_SUB_EN
            op_q        <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        a_q         <= bus.req_a;
                        b_q         <= bus.req_b;
                        exec_q      <= bus.req_exec;
`ifdef VALU_FADD_SUB_EN
                        op_q        <= bus.req_op;
`endif
                        data_q      <= '0;
                        nan_q       <= '0;
                        ovf_q       <= '0;
                        lane        <= '0;
                        req_ready_q <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (exec_q[lane]) begin
                        fadd_a <= a_lane;
`ifdef VALU_FADD_SUB_EN
                        fadd_b <= {b_lane[31] ^ op_q, b_lane[30:0]};
`else
                        fadd_b <= b_lane;
`endif
                        cnt    <= CW'(ADD_LAT);
                        state  <= WAIT;
                    end else if (lane == LAST) begin
                        state <= DONE;
                    end else begin
                        lane <= lane + LW'(1);
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    // Adder output is valid once ADD_LAT cycles have elapsed
                    if (cnt == CW'(1)) begin
                        data_q[{lane, 5'd0} +: 32] <= fadd_out;
                        nan_q[lane] <= fadd_nan;
                        ovf_q[lane] <= fadd_ovf;
                        if (lane == LAST) begin
                            state <= DONE;
                        end else begin
                            lane  <= lane + LW'(1);
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    rsp_valid_q <= 1'b1;
                    if (rsp_valid_q && bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_valu_fadd_lane_sequencer.sv
// Directed bench for valu_fadd_lane_sequencer with a table-driven adder stub.
// Honours VALU_FADD_SUB_EN when checking the subtract path.
module tb_valu_fadd_lane_sequencer;
    logic        clk;
    logic        rst_n;
    logic [31:0] fadd_a;
    logic [31:0] fadd_b;
    logic [31:0] fadd_out;
    logic        fadd_nan;
    logic        fadd_ovf;
    logic        busy;

    int checks;
    int errors;
    int toggles;

    valu_fadd_lane_sequencer_if #(.LANES(4)) bus ();

    valu_fadd_lane_sequencer #(
        .LANES(4),
        .ADD_LAT(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .fadd_a(fadd_a),
        .fadd_b(fadd_b),
        .fadd_out(fadd_out),
        .fadd_nan(fadd_nan),
        .fadd_ovf(fadd_ovf),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub adder: known FP32 pairs are exact, anything else returns a^b
    always_comb begin
        fadd_out = fadd_a ^ fadd_b;
        fadd_nan = 1'b0;
        fadd_ovf = 1'b0;
        if (fadd_a == 32'h3F800000 && fadd_b == 32'h40000000) begin
            fadd_out = 32'h40400000;
        end else if (fadd_a == 32'h3F800000 && fadd_b == 32'hC0000000) begin
            fadd_out = 32'hBF800000;
        end else if (fadd_a == 32'h7F800000 && fadd_b == 32'hFF800000) begin
            fadd_out = 32'h7FC00000;
            fadd_nan = 1'b1;
        end else if (fadd_a == 32'h7F7FFFFF && fadd_b == 32'h7F7FFFFF) begin
            fadd_out = 32'h7F800000;
            fadd_ovf = 1'b1;
        end
    end

    localparam logic [127:0] A2 = {32'h01000000, 32'h00010000,
                                   32'h00000100, 32'h00000001};
    localparam logic [127:0] B2 = {32'h10000000, 32'h00100000,
                                   32'h00001000, 32'h00000010};
    localparam logic [127:0] X2 = {32'h11000000, 32'h00110000,
                                   32'h00001100, 32'h00000011};

    function automatic logic [127:0] rep(input logic [31:0] v);
        return {4{v}};
    endfunction

    task automatic send(input logic [127:0] a, input logic [127:0] b,
                        input logic [3:0] ex, input logic op);
        int n;
        n = 0;
        while (!bus.req_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_exec  = ex;
        bus.req_op    = op;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        logic [31:0] prev;
        cyc = -1;
        toggles = 0;
        prev = fadd_a;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (fadd_a !== prev) toggles++;
            prev = fadd_a;
            if (bus.rsp_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
            busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: rdy=%b vld=%b busy=%b want 1 0 0",
                     bus.req_ready, bus.rsp_valid, busy);
        end
        checks++;
        if (fadd_a !== 32'h0 || fadd_b !== 32'h0 || bus.rsp_data !== 128'h0 ||
            bus.rsp_nan_mask !== 4'h0 || bus.rsp_ovf_mask !== 4'h0) begin
            errors++;
            $display("FAIL reset_data: a=%h b=%h d=%h want zeros",
                     fadd_a, fadd_b, bus.rsp_data);
        end
    endtask

    task automatic test_all_active();
        int cyc;
        send(rep(32'h3F800000), rep(32'h40000000), 4'b1111, 1'b0);
        wait_rsp(cyc);
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL all_lat: got %0d want 9", cyc);
        end
        checks++;
        if (bus.rsp_data !== rep(32'h40400000)) begin
            errors++;
            $display("FAIL all_data: got %h want %h",
                     bus.rsp_data, rep(32'h40400000));
        end
        checks++;
        if (bus.rsp_nan_mask !== 4'h0 || bus.rsp_ovf_mask !== 4'h0 ||
            busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL all_flags: nan=%b ovf=%b busy=%b rdy=%b want 0 0 1 0",
                     bus.rsp_nan_mask, bus.rsp_ovf_mask, busy, bus.req_ready);
        end
        handshake();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL all_release: vld=%b rdy=%b busy=%b want 0 1 0",
                     bus.rsp_valid, bus.req_ready, busy);
        end
    endtask

    task automatic test_sparse();
        int cyc;
        send(A2, B2, 4'b0101, 1'b0);
        wait_rsp(cyc);
        checks++;
        if (cyc !== 7) begin
            errors++;
            $display("FAIL sparse_lat: got %0d want 7", cyc);
        end
        checks++;
        if (bus.rsp_data !== {32'h0, 32'h00110000, 32'h0, 32'h00000011}) begin
            errors++;
            $display("FAIL sparse_data: got %h want %h", bus.rsp_data,
                     {32'h0, 32'h00110000, 32'h0, 32'h00000011});
        end
        checks++;
        if (toggles !== 2 || fadd_a !== 32'h00010000) begin
            errors++;
            $display("FAIL sparse_toggles: got %0d/%h want 2/00010000",
                     toggles, fadd_a);
        end
        handshake();
    endtask

    task automatic test_flags();
        int cyc;
        send({32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h3F800000},
             {32'h7F7FFFFF, 32'hFF800000, 32'h40000000, 32'h40000000},
             4'b1111, 1'b0);
        wait_rsp(cyc);
        checks++;
        if (bus.rsp_nan_mask !== 4'b0100 || bus.rsp_ovf_mask !== 4'b1000) begin
            errors++;
            $display("FAIL flags_mask: nan=%b ovf=%b want 0100 1000",
                     bus.rsp_nan_mask, bus.rsp_ovf_mask);
        end
        checks++;
        if (bus.rsp_data !== {32'h7F800000, 32'h7FC00000,
                              32'h40400000, 32'h40400000} || cyc !== 9) begin
            errors++;
            $display("FAIL flags_data: got %h lat %0d", bus.rsp_data, cyc);
        end
        handshake();
    endtask

    task automatic test_zero_exec();
        int cyc;
        send(A2, B2, 4'b0000, 1'b0);
        wait_rsp(cyc);
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL zero_lat: got %0d want 5", cyc);
        end
        checks++;
        if (bus.rsp_data !== 128'h0 || bus.rsp_nan_mask !== 4'h0 ||
            bus.rsp_ovf_mask !== 4'h0 || toggles !== 0) begin
            errors++;
            $display("FAIL zero_data: got %h nan=%b ovf=%b tog=%0d want zeros",
                     bus.rsp_data, bus.rsp_nan_mask, bus.rsp_ovf_mask, toggles);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int cyc;
        send(rep(32'h3F800000), rep(32'h40000000), 4'b1111, 1'b0);
        wait_rsp(cyc);
        bus.req_a     = A2;
        bus.req_b     = B2;
        bus.req_exec  = 4'b1111;
        bus.req_op    = 1'b0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
                busy !== 1'b1 || bus.rsp_data !== rep(32'h40400000)) begin
                errors++;
                $display("FAIL hold_%0d: vld=%b rdy=%b d=%h want 1 0 %h", i,
                         bus.rsp_valid, bus.req_ready, bus.rsp_data,
                         rep(32'h40400000));
            end
        end
        handshake();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: vld=%b rdy=%b busy=%b want 0 1 0",
                     bus.rsp_valid, bus.req_ready, busy);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_accept: rdy=%b busy=%b want 0 1",
                     bus.req_ready, busy);
        end
        wait_rsp(cyc);
        checks++;
        if (bus.rsp_data !== X2 || cyc !== 9) begin
            errors++;
            $display("FAIL hold_next: got %h lat %0d want %h lat 9",
                     bus.rsp_data, cyc, X2);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        int cyc;
        send(A2, B2, 4'b1111, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || busy !== 1'b0 ||
            fadd_a !== 32'h0 || fadd_b !== 32'h0 || bus.rsp_data !== 128'h0) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b vld=%b busy=%b a=%h d=%h",
                     bus.req_ready, bus.rsp_valid, busy, fadd_a, bus.rsp_data);
        end
        send(rep(32'h3F800000), rep(32'h40000000), 4'b1111, 1'b0);
        wait_rsp(cyc);
        checks++;
        if (bus.rsp_data !== rep(32'h40400000) || cyc !== 9) begin
            errors++;
            $display("FAIL mid_fresh: got %h lat %0d", bus.rsp_data, cyc);
        end
        handshake();
    endtask

    task automatic test_sub();
        int cyc;
        logic [31:0] exp_b;
        logic [31:0] exp_r;
`ifdef VALU_FADD_SUB_EN
        exp_b = 32'hC0000000;
        exp_r = 32'hBF800000;
`else
        exp_b = 32'h40000000;
        exp_r = 32'h40400000;
`endif
        send(rep(32'h3F800000), rep(32'h40000000), 4'b0001, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (fadd_b !== exp_b) begin
            errors++;
            $display("FAIL sub_b: got %h want %h", fadd_b, exp_b);
        end
        wait_rsp(cyc);
        checks++;
        if (bus.rsp_data !== {96'h0, exp_r}) begin
            errors++;
            $display("FAIL sub_data: got %h want %h", bus.rsp_data, {96'h0, exp_r});
        end
        handshake();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        toggles       = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_exec  = '0;
        bus.req_op    = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_all_active();
        test_sparse();
        test_flags();
        test_zero_exec();
        test_back_to_back();
        test_reset_mid();
        test_sub();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
